// File: rtl/cail_param_bank.sv
// Calibration parameter bank: CH_NUM x TYPE_NUM words with host read/write and a
// byte-serial EEPROM load/save sequencer (checksum-protected) on the iic_ctrl interface.
module cail_param_bank #(
  parameter int          CH_NUM   = 16,
  parameter int          TYPE_NUM = 4,
  parameter int          DATA_W   = 32,
  parameter logic [15:0] EE_BASE  = 16'h0000,
  parameter int          WR_GAP   = 250000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic [3:0]        ch,
  input  logic [1:0]        ptype,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] result,
  output logic              rd_valid,
  input  logic              load_req,
  input  logic              save_req,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              iic_w_req,
  output logic              iic_r_req,
  output logic [15:0]       iic_addr,
  output logic [7:0]        iic_wdata,
  input  logic [7:0]        iic_rdata,
  input  logic              iic_r_valid,
  input  logic              iic_wr_done,
  input  logic              iic_ack
);
  localparam int N     = CH_NUM * TYPE_NUM;
  localparam int BYTES = DATA_W / 8;
  localparam int NB    = N * BYTES;            // byte index of the checksum
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int NW    = $clog2(NB + 1);
  localparam int GW    = (WR_GAP > 1) ? $clog2(WR_GAP + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_REQ, ST_RD_WAIT, ST_WR_REQ, ST_WR_WAIT, ST_WR_GAP, ST_CHK, ST_FIN
  } state_t;

  state_t                   state, state_nx;
  logic [N-1:0][DATA_W-1:0] mem;
  logic [NW-1:0]            n;
  logic [7:0]               sum;
  logic [GW-1:0]            gap;

  logic              acc_ok, host_we, load_we, last, gap_end;
  logic [IW-1:0]     hidx, sw;
  int                sh;
  logic [7:0]        ee_byte, save_byte;
  logic [DATA_W-1:0] lane_mask, lane_data;

  // Host index decode; out-of-range accesses collapse to word 0 but are gated by acc_ok.
  always_comb begin
    acc_ok  = (32'(ch) < CH_NUM) && (32'(ptype) < TYPE_NUM);
    hidx    = acc_ok ? IW'(32'(ch) * TYPE_NUM + 32'(ptype)) : '0;
    host_we = wr_req && acc_ok && !busy;
  end

  // Sequencer byte lane: byte k=0 is the word MSB.
  always_comb begin
    last      = (32'(n) == NB);
    sw        = last ? '0 : IW'(32'(n) / BYTES);
    sh        = 8 * (BYTES - 1 - (int'(n) % BYTES));
    ee_byte   = 8'(mem[sw] >> sh);
    save_byte = last ? (8'd0 - sum) : ee_byte;
    lane_mask = DATA_W'(8'hFF) << sh;
    lane_data = DATA_W'(iic_rdata) << sh;
    load_we   = (state == ST_RD_WAIT) && iic_r_valid && !last;
    gap_end   = (32'(gap) + 1 >= WR_GAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem <= '0;
    else if (load_we) mem[sw] <= (mem[sw] & ~lane_mask) | lane_data;
    else if (host_we) mem[hidx] <= in_data;
  end

  // Read samples the array before any same-edge write, so a colliding read sees the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) result <= acc_ok ? mem[hidx] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (load_req) state_nx = ST_RD_REQ;
                  else if (save_req) state_nx = ST_WR_REQ;
      ST_RD_REQ:  state_nx = ST_RD_WAIT;
      ST_RD_WAIT: if (iic_wr_done) state_nx = iic_ack ? ST_FIN : (last ? ST_CHK : ST_RD_REQ);
      ST_CHK:     state_nx = ST_FIN;
      ST_WR_REQ:  state_nx = ST_WR_WAIT;
      ST_WR_WAIT: if (iic_wr_done) state_nx = iic_ack ? ST_FIN : ST_WR_GAP;
      ST_WR_GAP:  if (gap_end) state_nx = last ? ST_FIN : ST_WR_REQ;
      ST_FIN:     state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n   <= '0;
      sum <= '0;
      gap <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (load_req || save_req) begin
          n   <= '0;
          sum <= '0;
          err <= 1'b0;
        end
        ST_RD_WAIT: begin
          if (iic_r_valid) sum <= sum + iic_rdata;
          if (iic_wr_done) begin
            if (iic_ack)   err <= 1'b1;
            else if (!last) n  <= n + 1'b1;
          end
        end
        ST_CHK:     if (sum != 8'd0) err <= 1'b1;
        ST_WR_REQ: begin
          gap <= '0;
          if (!last) sum <= sum + save_byte;
        end
        ST_WR_WAIT: begin
          gap <= '0;
          if (iic_wr_done && iic_ack) err <= 1'b1;
        end
        ST_WR_GAP: begin
          gap <= gap + 1'b1;
          if (gap_end && !last) n <= n + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Address and write data are held for the whole transaction, zero when idle.
  always_comb begin
    busy      = (state != ST_IDLE) && (state != ST_FIN);
    done      = (state == ST_FIN);
    iic_r_req = (state == ST_RD_REQ);
    iic_w_req = (state == ST_WR_REQ);
    iic_addr  = busy ? EE_BASE + 16'(n) : 16'h0000;
    iic_wdata = (state == ST_WR_REQ || state == ST_WR_WAIT || state == ST_WR_GAP) ? save_byte : 8'h00;
  end

endmodule

// File: tb/tb_cail_param_bank.sv
// Scoreboard bench for cail_param_bank: host path, EEPROM save/load through a byte-level
// EEPROM model, checksum corruption, NACK abort and reset mid-save.
module tb_cail_param_bank;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wr_req, rd_req, load_req, save_req;
  logic [3:0]  ch;
  logic [1:0]  ptype;
  logic [31:0] in_data, result;
  logic        rd_valid, busy, done, err, iic_w_req, iic_r_req;
  logic [15:0] iic_addr;
  logic [7:0]  iic_wdata, iic_rdata;
  logic        iic_r_valid, iic_wr_done, iic_ack;

  // second bank for range checks: 8 channels x 3 types
  logic        wr2, rd2;
  logic [3:0]  ch2;
  logic [1:0]  ty2;
  logic [31:0] d2, result2;
  logic        rv2, b2, dn2, e2, wq2, rq2;
  logic [15:0] a2;
  logic [7:0]  wd2;

  cail_param_bank #(.CH_NUM(16), .TYPE_NUM(4), .DATA_W(32), .EE_BASE(16'h0000), .WR_GAP(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req), .ch(ch), .ptype(ptype),
    .in_data(in_data), .result(result), .rd_valid(rd_valid), .load_req(load_req),
    .save_req(save_req), .busy(busy), .done(done), .err(err), .iic_w_req(iic_w_req),
    .iic_r_req(iic_r_req), .iic_addr(iic_addr), .iic_wdata(iic_wdata), .iic_rdata(iic_rdata),
    .iic_r_valid(iic_r_valid), .iic_wr_done(iic_wr_done), .iic_ack(iic_ack));

  cail_param_bank #(.CH_NUM(8), .TYPE_NUM(3), .DATA_W(32), .EE_BASE(16'h0000), .WR_GAP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_req(wr2), .rd_req(rd2), .ch(ch2), .ptype(ty2),
    .in_data(d2), .result(result2), .rd_valid(rv2), .load_req(1'b0),
    .save_req(1'b0), .busy(b2), .done(dn2), .err(e2), .iic_w_req(wq2),
    .iic_r_req(rq2), .iic_addr(a2), .iic_wdata(wd2), .iic_rdata(8'h00),
    .iic_r_valid(1'b0), .iic_wr_done(1'b0), .iic_ack(1'b0));

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  logic [31:0] rd_q[$], rd2_q[$];
  logic [23:0] sv_q[$];          // {addr, byte} expected per EEPROM write
  logic [7:0]  ee[512];
  logic [31:0] mdl[64];
  int          txn = 0, nack_at = -1, w_cnt = 0;

  // EEPROM behind iic_ctrl: responds two cycles after a request, NACKs transaction nack_at.
  initial begin
    logic [15:0] addr;
    logic        isw, nack;
    iic_rdata = 8'h00; iic_r_valid = 1'b0; iic_wr_done = 1'b0; iic_ack = 1'b0;
    for (int i = 0; i < 512; i++) ee[i] = 8'h00;
    forever begin
      @(negedge clk);
      iic_wr_done = 1'b0; iic_ack = 1'b0; iic_r_valid = 1'b0;
      if (iic_w_req || iic_r_req) begin
        addr = iic_addr; isw = iic_w_req;
        txn++;
        nack = (txn == nack_at);
        if (isw) begin
          w_cnt++;
          ee[addr[8:0]] = iic_wdata;
          if (sv_q.size() == 0) chk("w_extra", sv_q.size(), 1);
          else chk("wbyte", {iic_addr, iic_wdata}, sv_q.pop_front());
        end
        repeat (2) @(negedge clk);
        if (!isw) begin
          iic_rdata = ee[addr[8:0]]; iic_r_valid = 1'b1;
          @(negedge clk);
          iic_r_valid = 1'b0;
        end
        iic_wr_done = 1'b1; iic_ack = nack;
      end
    end
  end

  always @(negedge clk) begin
    if (rd_valid) begin
      if (rd_q.size() == 0) chk("rd_extra", rd_q.size(), 1);
      else chk("rd", result, rd_q.pop_front());
    end
    if (rv2) begin
      if (rd2_q.size() == 0) chk("rd2_extra", rd2_q.size(), 1);
      else chk("rd2", result2, rd2_q.pop_front());
    end
  end

  task automatic hwr(input int c, input int t, input logic [31:0] d);
    @(negedge clk); wr_req = 1'b1; ch = 4'(c); ptype = 2'(t); in_data = d;
    @(negedge clk); wr_req = 1'b0;
  endtask
  task automatic hrd(input int c, input int t, input logic [31:0] exp);
    @(negedge clk); rd_req = 1'b1; ch = 4'(c); ptype = 2'(t); rd_q.push_back(exp);
    @(negedge clk); rd_req = 1'b0;
  endtask
  task automatic hwr2(input int c, input int t, input logic [31:0] d);
    @(negedge clk); wr2 = 1'b1; ch2 = 4'(c); ty2 = 2'(t); d2 = d;
    @(negedge clk); wr2 = 1'b0;
  endtask
  task automatic hrd2(input int c, input int t, input logic [31:0] exp);
    @(negedge clk); rd2 = 1'b1; ch2 = 4'(c); ty2 = 2'(t); rd2_q.push_back(exp);
    @(negedge clk); rd2 = 1'b0;
  endtask

  // Expected save stream from the bench model: MSB-first bytes then two's-complement sum.
  function automatic void push_save(input int cnt);
    logic [7:0] s, b;
    s = 8'h00;
    for (int i = 0; i < 256; i++) begin
      b = 8'(mdl[i/4] >> (8 * (3 - i % 4)));
      s = s + b;
      if (i < cnt) sv_q.push_back({16'(i), b});
    end
    if (cnt > 256) sv_q.push_back({16'd256, 8'(-s)});
  endfunction

  task automatic pulse(input bit is_load);
    @(negedge clk);
    if (is_load) load_req = 1'b1; else save_req = 1'b1;
    @(negedge clk); load_req = 1'b0; save_req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 20000) begin @(negedge clk); k++; end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_req = 0; rd_req = 0; ch = 0; ptype = 0; in_data = 0; load_req = 0; save_req = 0;
    wr2 = 0; rd2 = 0; ch2 = 0; ty2 = 0; d2 = 0;
    repeat (3) @(negedge clk);
    chk("rst_out", {result, rd_valid, busy, done, err, iic_w_req, iic_r_req}, '0);
    chk("rst_iic", {iic_addr, iic_wdata}, '0);
    chk("rst2", {result2, rv2, b2, dn2, e2, wq2, rq2, a2, wd2}, '0);
    rst_n = 1'b1;

    // host path
    hrd(15, 3, 32'h0);
    hwr(3, 2, 32'hDEADBEEF);
    hrd(3, 2, 32'hDEADBEEF);
    @(negedge clk); wr_req = 1; rd_req = 1; ch = 3; ptype = 2; in_data = 32'h12345678;
    rd_q.push_back(32'hDEADBEEF);
    @(negedge clk); wr_req = 0; rd_req = 0;
    hrd(3, 2, 32'h12345678);

    // range checks on the 8x3 bank
    hwr2(9, 0, 32'hAAAA0000);
    hwr2(1, 3, 32'hBBBB0000);
    hwr2(1, 2, 32'hCCCC0000);
    hrd2(9, 0, 32'h0);
    hrd2(1, 3, 32'h0);
    hrd2(2, 0, 32'h0);
    hrd2(1, 2, 32'hCCCC0000);
    hrd2(7, 2, 32'h0);

    // fill and save
    for (int i = 0; i < 64; i++) begin
      mdl[i] = 32'(i) * 32'h01010101;
      hwr(i / 4, i % 4, mdl[i]);
    end
    push_save(257); w_cnt = 0;
    pulse(1'b0);
    chk("save_busy", busy, 1);
    hwr(0, 0, 32'hFFFFFFFF);
    hrd(0, 0, 32'h0);
    wait_done("save");
    chk("save_err", err, 0);
    @(negedge clk);
    chk("save_done1", done, 0);
    chk("save_cnt", w_cnt, 257);
    chk("save_q", sv_q.size(), 0);
    chk("ee_cks", ee[256], 8'h80);

    // reset then load the saved image
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    hrd(4, 1, 32'h0);
    pulse(1'b1);
    wait_done("load");
    chk("load_err", err, 0);
    @(negedge clk);
    chk("load_done1", done, 0);
    for (int i = 0; i < 64; i++) hrd(i / 4, i % 4, mdl[i]);

    // checksum failure
    ee[5] = ee[5] ^ 8'h40;
    mdl[1] = 32'h01410101;
    pulse(1'b1);
    wait_done("cks");
    chk("cks_err", err, 1);
    hrd(0, 1, 32'h01410101);
    ee[5] = ee[5] ^ 8'h40;

    // NACK on the 10th write
    nack_at = txn + 10; push_save(10); w_cnt = 0;
    pulse(1'b0);
    chk("err_clr", err, 0);
    wait_done("nack");
    chk("nack_err", err, 1);
    repeat (30) @(negedge clk);
    chk("nack_cnt", w_cnt, 10);
    chk("nack_q", sv_q.size(), 0);

    // reset mid-save
    nack_at = -1; push_save(257);
    pulse(1'b0);
    repeat (60) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("rst_mid", {busy, iic_w_req, err, done}, '0);
    sv_q.delete();
    @(negedge clk); rst_n = 1;
    hrd(0, 3, 32'h0);
    hrd(2, 0, 32'h0);
    hrd(15, 3, 32'h0);
    repeat (10) @(negedge clk);
    chk("rd_q_empty", rd_q.size() + rd2_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cail_param_bank.md
Name: cail_param_bank

Overview:
- Parametrised calibration-parameter store: CH_NUM channels × TYPE_NUM parameter types, each DATA_W bits wide, held in a register array.
- Host side gives single-cycle writes and registered reads.
- Sequencer side runs a full-bank load from EEPROM or save to EEPROM, one byte per transaction, through the existing iic_ctrl byte interface.
- Successor to the fixed 16-channel calibration store. It adds EEPROM persistence, checksum protection and range checking.

Parameters:
- CH_NUM, 16, number of channels (1..16).
- TYPE_NUM, 4, parameter types per channel (1..4).
- DATA_W, 32, word width; must be a multiple of 8. BYTES = DATA_W/8.
- EE_BASE, 16'h0000, EEPROM start address of the bank.
- WR_GAP, 250000, idle cycles after each EEPROM byte write (5 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_req  in  1  host write strobe.
- rd_req  in  1  host read strobe.
- ch  in  4  channel index.
- type  in  2  parameter type index.
- in_data  in  DATA_W  host write data.
- result  out  DATA_W  read data.
- rd_valid  out  1  result valid pulse.
- load_req  in  1  start EEPROM→bank load.
- save_req  in  1  start bank→EEPROM save.
- busy  out  1  sequencer active.
- done  out  1  one-cycle pulse at end of load/save.
- err  out  1  sticky error flag; cleared by the next load_req/save_req.
- iic_w_req  out  1  byte-write request pulse.
- iic_r_req  out  1  byte-read request pulse.
- iic_addr  out  16  EEPROM byte address.
- iic_wdata  out  8  byte to write.
- iic_rdata  in  8  byte read.
- iic_r_valid  in  1  iic_rdata valid pulse.
- iic_wr_done  in  1  transaction complete pulse.
- iic_ack  in  1  NACK flag, sampled with iic_wr_done; 1 = NACK.

Behaviour:
- Reset:
  - All array words 0.
  - result 0; rd_valid, busy, done and err 0.
  - iic_w_req and iic_r_req 0; iic_addr and iic_wdata 0.
  - Sequencer in IDLE.
- Index:
  - idx = ch*TYPE_NUM + type.
  - Access is valid only when ch < CH_NUM and type < TYPE_NUM.
- Host write:
  - Valid access with busy=0: word updated on the wr_req edge.
  - Invalid access or busy=1: write ignored.
- Host read:
  - rd_req → result and rd_valid registered on the next edge (latency 1).
  - Served even while busy; returns the current array content.
  - Invalid index → result 0, rd_valid still asserted.
- Simultaneous wr_req and rd_req at the same index: read returns the old word.
- Byte map:
  - Word idx byte k (k=0 is the MSB) lives at EE_BASE + idx*BYTES + k.
  - Checksum byte lives at EE_BASE + CH_NUM*TYPE_NUM*BYTES.
  - Checksum value: the 8-bit sum of all stored bytes, including the checksum, equals 0.
- Request acceptance:
  - Requests are accepted only in IDLE.
  - load_req has priority when both requests are high.
  - Accepting a request clears err, sets busy=1, and clears the byte counter n and the running sum.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, WR_GAP, CHK, FIN.
- Load path:
  - RD_REQ: iic_r_req high for 1 cycle with iic_addr = EE_BASE+n.
  - RD_WAIT: on iic_r_valid, write the byte into the array lane and add it to the sum.
  - On iic_wr_done:
    - NACK → err=1, go to FIN.
    - Else, if n = last data byte+1 (checksum fetched) → CHK.
    - Else n++ and return to RD_REQ.
  - CHK: sum ≠ 0 → err=1; the array keeps the loaded data. Then go to FIN.
- Save path:
  - WR_REQ: iic_w_req high for 1 cycle; iic_wdata = array byte, or −sum for the checksum byte.
  - WR_WAIT: on iic_wr_done:
    - NACK → err=1, go to FIN.
    - Else → WR_GAP.
  - WR_GAP: count WR_GAP cycles, then either n++ and go to WR_REQ, or go to FIN after the checksum byte.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Total transactions per load or save = CH_NUM*TYPE_NUM*BYTES + 1.
- iic_addr is 16-bit and wraps modulo 2^16; EE_BASE must be chosen so the bank does not wrap.
- Reset mid-operation: everything returns to reset values, the array is cleared, and the EEPROM is left partially written; no error is reported.
- load_req or save_req while busy: ignored.

Test Plan:
- Host write/read: write ch=3,type=2,in_data=32'hDEADBEEF, then rd_req → next-cycle result=32'hDEADBEEF, rd_valid=1; ch=15,type=3 read after reset → 0.
- Range and busy: CH_NUM=8, write to ch=9 → ignored, read of ch=9 → 0; wr_req while busy → word unchanged.
- Save with WR_GAP=4:
  - Fill all words with idx*32'h01010101, then save_req.
  - Required: 257 iic_w_req pulses at addresses 0..256 in MSB-first order.
  - Required: last byte = two's-complement of the byte sum; done pulse; err=0.
- Load: EEPROM model holds the image from the save test, array reset first, then load_req → all words restored, err=0, done one cycle.
- Checksum fail: corrupt byte 5 of the EEPROM model, load → err=1, done pulse, word 1 shows the corrupt byte.
- NACK and reset:
  - iic_ack=1 on the 10th transaction → err=1, sequencer stops, no 11th request.
  - rst_n low mid-save → busy=0, array=0, iic_w_req=0.
